fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage that owns the architectural program counter. It sits directly upstream of `PCUnit`: it fetches the instruction at `pc` from instruction memory and presents `pc` and the instruction to decode/execute. It then retires the instruction by loading `PCUnit`'s computed next address (`PC_out`) back into `pc`. It also detects HLT, counts taken branches, and optionally times out a stalled memory.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: value loaded into `pc` on reset.
- `TIMEOUT_CYCLES`, default 16: maximum FETCH-state cycles before timeout. Used only with `FETCH_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  16  byte address of the fetch; always equals `pc`.
- `imem_data`  in  16  returned instruction.
- `imem_valid`  in  1  `imem_data` is valid this cycle.
- `pc`  out  16  address of the current instruction; feeds `PCUnit.PC_in`.
- `instr`  out  16  current instruction register.
- `instr_valid`  out  1  `instr` and `pc` are valid for execute.
- `instr_ack`  in  1  execute has finished this instruction and `next_pc` is final.
- `next_pc`  in  16  from `PCUnit.PC_out`.
- `branch_taken`  in  1  from `PCUnit.branch_taken`.
- `halted`  out  1  sticky; an HLT instruction has retired.
- `branch_count`  out  16  saturating count of retired taken branches.
- `timeout_err`  out  1  sticky memory timeout (see Configuration).

## Operation
- States:
  - FETCH: `imem_req`=1. When `imem_valid`=1, load `instr` from `imem_data` and go to ISSUE. Otherwise stay in FETCH.
  - ISSUE: `instr_valid`=1. When `instr_ack`=1, retire the instruction (see below). Otherwise hold all state.
  - HALT: terminal. `imem_req`=0, `instr_valid`=0, `halted`=1. `pc` holds the HLT address. Only `rst` exits.
- Retire, on `instr_ack` in ISSUE:
  - If `instr[15:12]`==4'hF (HLT), go to HALT and leave `pc` unchanged.
  - Otherwise load `pc` from `next_pc` and go to FETCH.
  - If `branch_taken`=1, increment `branch_count`. It saturates at 16'hFFFF and does not wrap.
- Ignored inputs:
  - `imem_valid` outside FETCH.
  - `instr_ack` outside ISSUE.
  - `next_pc` and `branch_taken` except in the retire cycle.
- `pc` arithmetic is 16-bit modulo. `next_pc`=16'hFFFE+2 wrapping to 16'h0000 is accepted unchanged. Bit 0 of `next_pc` is forced to 0.
- `rst` has priority over every other event, including a simultaneous `imem_valid` or `instr_ack`.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `instr`=16'h0000, `branch_count`=0.
  - `instr_valid`=0, `halted`=0, `timeout_err`=0.
  - State = FETCH. `imem_req` is 0 during the reset cycle and 1 from the first cycle after `rst` deasserts.
- Zero-wait memory (`imem_valid` in the same cycle as `imem_req`): `instr_valid` is 1 on the next cycle.
- Best case is 2 cycles per instruction (FETCH, then ISSUE with `instr_ack` in the same cycle).
- Each wait cycle on `imem_valid` or `instr_ack` adds one cycle.
- On retire, the updated `pc` is visible on `imem_addr` the following cycle.
- `instr` and `pc` are stable throughout ISSUE.
- `halted` rises the cycle after the HLT `instr_ack`.
- Reset asserted mid-FETCH or mid-ISSUE: everything returns to reset values on the next edge, and the in-flight instruction is dropped.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A cycle counter counts consecutive FETCH cycles without `imem_valid`.
  - When the count reaches `TIMEOUT_CYCLES`, `timeout_err` sets (sticky until `rst`) and the state goes to HALT. `halted` is not set.
  - The counter clears on entry to FETCH.
- `FETCH_TIMEOUT_EN` undefined: no counter is built, `timeout_err` is tied to 0, and FETCH waits indefinitely.

## Structure
- Shared package `fetch_pkg`:
  - Opcode constant `OP_HLT`=4'hF.
  - State enum FETCH/ISSUE/HALT.
  - `PC_W`=16.
- One sub-module, `fetch_timeout_ctr`: the timeout counter, instantiated only under `FETCH_TIMEOUT_EN`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `RESET_PC`=16'h0010 → `pc`=16'h0010, `instr_valid`=0, `imem_req`=0 during reset and 1 on the first cycle after.
- **Sequential fetch:** zero-wait memory, `instr_ack` every ISSUE cycle, `next_pc`=`pc`+2 → `imem_addr` runs 0x0000, 0x0002, 0x0004 at one instruction per 2 cycles; `branch_count`=0.
- **Taken branch:** retire with `branch_taken`=1 and `next_pc`=16'h0040 → next `imem_addr`=16'h0040 and `branch_count` increments by 1. Preload `branch_count` at 16'hFFFF → it stays at 16'hFFFF.
- **Stalls:** `imem_valid` delayed 3 cycles, then `instr_ack` delayed 2 cycles → `instr` is captured only on `imem_valid`, `pc` and `instr` are stable throughout ISSUE, and no retire occurs before `instr_ack`.
- **HLT:** `imem_data`=16'hF000 at `pc`=16'h0006, then acked → `halted`=1 the next cycle, `pc` stays at 16'h0006, `imem_req` stays 0, and later `instr_ack`/`imem_valid` pulses are ignored.
- **Timeout and mid-operation reset:** with `FETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, withhold `imem_valid` → `timeout_err`=1 after 4 FETCH cycles, `halted`=0. Separately, assert `rst` in the same cycle as `instr_ack` → `pc` returns to `RESET_PC` and `branch_count` is not incremented.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Used by fetch_unit and, when FETCH_TIMEOUT_EN is defined, by its timeout counter.
package fetch_pkg;

    localparam int         PC_W   = 16;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    // The opcode lives in the top nibble of every instruction word.
    function automatic logic is_hlt(input logic [PC_W-1:0] ins);
        return ins[PC_W-1 -: 4] == OP_HLT;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts consecutive stalled FETCH cycles and flags when TIMEOUT_CYCLES is reached.
// Only instantiated by fetch_unit when FETCH_TIMEOUT_EN is defined.
module fetch_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic stall,
    output logic expired
);

    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (stall) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Fires in the cycle that completes the TIMEOUT_CYCLES-th stalled cycle.
    assign expired = stall && !clear && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches, issues, retires via next_pc, detects HLT.
// Define FETCH_TIMEOUT_EN to build the stalled-memory timeout (timeout_err, TIMEOUT_CYCLES).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC       = 16'h0000,
    parameter int              TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [PC_W-1:0] imem_data,
    input  logic            imem_valid,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] instr,
    output logic            instr_valid,
    input  logic            instr_ack,
    input  logic [PC_W-1:0] next_pc,
    input  logic            branch_taken,
    output logic            halted,
    output logic [PC_W-1:0] branch_count,
    output logic            timeout_err
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0] branch_count_q, branch_count_d;
    logic            halted_q, halted_d;
    logic            timeout_err_q, timeout_err_d;

    logic retire;
    logic timeout_hit;
    logic unused_next_pc_lsb;

    assign retire             = (state_q == ISSUE) && instr_ack;
    assign unused_next_pc_lsb = next_pc[0];

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != FETCH),
        .stall  ((state_q == FETCH) && !imem_valid),
        .expired(timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (imem_valid) begin
                    state_d = ISSUE;
                end else if (timeout_hit) begin
                    state_d = HALT;
                end
            end
            ISSUE: begin
                if (instr_ack) begin
                    state_d = is_hlt(instr_q) ? HALT : FETCH;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Outputs are gated by rst so nothing is requested or issued during a reset cycle.
    always_comb begin
        imem_req    = !rst && (state_q == FETCH);
        instr_valid = !rst && (state_q == ISSUE);
    end

    // Datapath next values
    always_comb begin
        pc_d           = pc_q;
        instr_d        = instr_q;
        branch_count_d = branch_count_q;
        halted_d       = halted_q;
        timeout_err_d  = timeout_err_q;

        if ((state_q == FETCH) && imem_valid) begin
            instr_d = imem_data;
        end

        if (retire) begin
            if (is_hlt(instr_q)) begin
                halted_d = 1'b1;
            end else begin
                pc_d = {next_pc[PC_W-1:1], 1'b0};
            end
            if (branch_taken && (branch_count_q != '1)) begin
                branch_count_d = branch_count_q + PC_W'(1);
            end
        end

        if (timeout_hit) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            instr_q        <= '0;
            branch_count_q <= '0;
            halted_q       <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            branch_count_q <= branch_count_d;
            halted_q       <= halted_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign instr        = instr_q;
    assign halted       = halted_q;
    assign branch_count = branch_count_q;
    assign timeout_err  = timeout_err_q;

endmodule
